// File: rtl/plic_gateway.sv
// Per-source PLIC gateway: synchronises raw IRQs, detects level/edge requests, tracks IDLE/PENDING/INSERVICE.
// Latency SYNC_STAGES+1 edges irq->pending_o; no backpressure, extra edges queue one deep then flag overflow.
module plic_gateway #(
    parameter int NSRC        = 31,
    parameter int SYNC_STAGES = 2
) (
    input  logic            gw_clock_i,
    input  logic            gw_reset_i,
    input  logic [NSRC-1:0] irq_i,
    input  logic            cfg_we_i,
    input  logic [NSRC-1:0] cfg_mode_i,
    output logic [NSRC-1:0] cfg_mode_o,
    input  logic            claim_valid_i,
    input  logic [4:0]      claim_id_i,
    input  logic            complete_valid_i,
    input  logic [4:0]      complete_id_i,
    input  logic            ovf_clr_i,
    output logic [NSRC-1:0] pending_o,
    output logic [NSRC-1:0] overflow_o
);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("plic_gateway: SYNC_STAGES must be at least 2");
    end

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_PENDING   = 2'd1,
        S_INSERVICE = 2'd2
    } gw_state_e;

    logic [SYNC_STAGES-1:0][NSRC-1:0] sync_q;
    logic [NSRC-1:0] sync_last;
    logic [NSRC-1:0] prev_q;
    logic [NSRC-1:0] mode_q;
    logic [NSRC-1:0] deferred_q, deferred_d;
    logic [NSRC-1:0] ovf_q, ovf_d;
    logic [NSRC-1:0] pending_q, pending_d;
    logic [NSRC-1:0] edge_req, act_req;
    logic [NSRC-1:0] claim_hit, complete_hit;
    gw_state_e       state_q [NSRC];
    gw_state_e       state_d [NSRC];

    assign sync_last  = sync_q[SYNC_STAGES-1];
    assign edge_req   = sync_last & ~prev_q;
    assign act_req    = (mode_q & edge_req) | (~mode_q & sync_last);
    assign cfg_mode_o = mode_q;
    assign pending_o  = pending_q;
    assign overflow_o = ovf_q;

    // IDs 0 and >NSRC never decode to a source, so stray events fall out naturally.
    always_comb begin
        claim_hit    = '0;
        complete_hit = '0;
        for (int k = 0; k < NSRC; k++) begin
            claim_hit[k]    = claim_valid_i    && (claim_id_i    == 5'(k + 1));
            complete_hit[k] = complete_valid_i && (complete_id_i == 5'(k + 1));
        end
    end

    always_comb begin
        logic edge_ev;
        edge_ev    = 1'b0;
        deferred_d = deferred_q;
        ovf_d      = ovf_clr_i ? '0 : ovf_q;
        pending_d  = '0;
        for (int k = 0; k < NSRC; k++) begin
            state_d[k] = state_q[k];
            edge_ev    = mode_q[k] & edge_req[k];
            case (state_q[k])
                S_IDLE: begin
                    if (act_req[k]) state_d[k] = S_PENDING;
                end
                S_PENDING: begin
                    if (claim_hit[k]) state_d[k] = S_INSERVICE;
                    if (edge_ev) begin
                        if (deferred_q[k]) ovf_d[k] = 1'b1;
                        else               deferred_d[k] = 1'b1;
                    end
                end
                S_INSERVICE: begin
                    if (complete_hit[k]) begin
                        // A queued edge and a fresh one cannot both be kept: re-pend once, flag the loss.
                        if (deferred_q[k] || edge_ev) state_d[k] = S_PENDING;
                        else                          state_d[k] = S_IDLE;
                        if (deferred_q[k] && edge_ev) ovf_d[k] = 1'b1;
                        deferred_d[k] = 1'b0;
                    end else if (edge_ev) begin
                        if (deferred_q[k]) ovf_d[k] = 1'b1;
                        else               deferred_d[k] = 1'b1;
                    end
                end
                default: state_d[k] = S_IDLE;
            endcase
            pending_d[k] = (state_d[k] == S_PENDING);
        end
        if (cfg_we_i) deferred_d = deferred_d & cfg_mode_i;
    end

    always_ff @(posedge gw_clock_i) begin
        if (gw_reset_i) begin
            sync_q     <= '0;
            prev_q     <= '0;
            mode_q     <= '0;
            deferred_q <= '0;
            ovf_q      <= '0;
            pending_q  <= '0;
            for (int k = 0; k < NSRC; k++) state_q[k] <= S_IDLE;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], irq_i};
            prev_q     <= sync_last;
            if (cfg_we_i) mode_q <= cfg_mode_i;
            deferred_q <= deferred_d;
            ovf_q      <= ovf_d;
            pending_q  <= pending_d;
            for (int k = 0; k < NSRC; k++) state_q[k] <= state_d[k];
        end
    end

endmodule

// File: tb/tb_plic_gateway.sv
// Directed bench for plic_gateway with default parameters (31 sources, 2 sync stages).
module tb_plic_gateway;

    logic        clk = 1'b0;
    logic        rst;
    logic [30:0] irq;
    logic        cfg_we;
    logic [30:0] cfg_mode;
    logic [30:0] mode_out;
    logic        claim_vld;
    logic [4:0]  claim_id;
    logic        cmpl_vld;
    logic [4:0]  cmpl_id;
    logic        ovf_clr;
    logic [30:0] pending;
    logic [30:0] overflow;

    int checks = 0;
    int errors = 0;

    plic_gateway #(.NSRC(31), .SYNC_STAGES(2)) dut (
        .gw_clock_i      (clk),
        .gw_reset_i      (rst),
        .irq_i           (irq),
        .cfg_we_i        (cfg_we),
        .cfg_mode_i      (cfg_mode),
        .cfg_mode_o      (mode_out),
        .claim_valid_i   (claim_vld),
        .claim_id_i      (claim_id),
        .complete_valid_i(cmpl_vld),
        .complete_id_i   (cmpl_id),
        .ovf_clr_i       (ovf_clr),
        .pending_o       (pending),
        .overflow_o      (overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [30:0] got, input logic [30:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic claim(input logic [4:0] id);
        claim_vld = 1'b1; claim_id = id;
        tick();
        claim_vld = 1'b0; claim_id = '0;
    endtask

    task automatic complete(input logic [4:0] id);
        cmpl_vld = 1'b1; cmpl_id = id;
        tick();
        cmpl_vld = 1'b0; cmpl_id = '0;
    endtask

    // One-cycle pulse; the edge is acted on at the third edge after it is raised.
    task automatic pulse(input int idx);
        irq[idx] = 1'b1;
        tick();
        irq[idx] = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        rst = 1'b1; irq = '0; cfg_we = 1'b0; cfg_mode = '0;
        claim_vld = 1'b0; claim_id = '0; cmpl_vld = 1'b0; cmpl_id = '0; ovf_clr = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check("reset_pending", pending, 31'h0);
        check("reset_overflow", overflow, 31'h0);
        check("reset_mode", mode_out, 31'h0);

        // Level source 3
        irq[2] = 1'b1;
        tick(); tick();
        check("lvl_not_yet", pending, 31'h0);
        tick();
        check("lvl_pending_edge3", pending, 31'h4);
        claim(5'd3);
        check("lvl_claimed", pending, 31'h0);
        tick(); tick();
        check("lvl_inservice_hold", pending, 31'h0);
        complete(5'd3);
        check("lvl_complete_idle", pending, 31'h0);
        tick();
        check("lvl_repend", pending, 31'h4);
        irq[2] = 1'b0;
        tick(); tick(); tick();
        check("lvl_pending_persists", pending, 31'h4);
        claim(5'd3);
        complete(5'd3);
        tick();
        check("lvl_cleared", pending, 31'h0);

        // Edge source 5
        cfg_we = 1'b1; cfg_mode = 31'h10;
        tick();
        cfg_we = 1'b0;
        check("mode_write", mode_out, 31'h10);
        pulse(4);
        check("edge_pending", pending, 31'h10);
        claim(5'd5);
        check("edge_claimed", pending, 31'h0);
        pulse(4);
        check("edge_deferred_hold", pending, 31'h0);
        complete(5'd5);
        check("edge_deferred_repend", pending, 31'h10);
        check("edge_no_ovf", overflow, 31'h0);
        claim(5'd5);
        pulse(4);
        pulse(4);
        check("edge_ovf_set", overflow, 31'h10);
        check("edge_ovf_inservice", pending, 31'h0);
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        check("ovf_cleared", overflow, 31'h0);
        irq[4] = 1'b1; tick(); irq[4] = 1'b0; tick();
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        check("ovf_clr_vs_set", overflow, 31'h10);
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        irq[4] = 1'b1; tick(); irq[4] = 1'b0; tick();
        complete(5'd5);
        check("cmpl_edge_pending", pending, 31'h10);
        check("cmpl_edge_ovf", overflow, 31'h10);
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        irq[4] = 1'b1; tick(); irq[4] = 1'b0; tick();
        claim(5'd5);
        check("claim_edge_inservice", pending, 31'h0);
        complete(5'd5);
        check("claim_edge_deferred", pending, 31'h10);
        check("claim_edge_no_ovf", overflow, 31'h0);

        // Stray events
        claim(5'd0);
        check("stray_claim0", pending, 31'h10);
        claim(5'd7);
        check("stray_claim7_idle", pending, 31'h10);
        irq[6] = 1'b1;
        tick(); tick(); tick();
        check("src7_pending", pending, 31'h50);
        complete(5'd7);
        check("stray_cmpl7_pending", pending, 31'h50);
        claim(5'd7);
        check("src7_claim_after_stray", pending, 31'h10);

        // Same-cycle claim src1 / complete src2
        irq[0] = 1'b1; irq[1] = 1'b1;
        tick(); tick(); tick();
        check("src12_pending", pending, 31'h13);
        claim(5'd2);
        check("src2_claimed", pending, 31'h11);
        claim_vld = 1'b1; claim_id = 5'd1; cmpl_vld = 1'b1; cmpl_id = 5'd2;
        tick();
        claim_vld = 1'b0; claim_id = '0; cmpl_vld = 1'b0; cmpl_id = '0;
        check("dual_event", pending, 31'h10);
        tick();
        check("dual_src2_repend", pending, 31'h12);

        // Overflow on src5 while PENDING, then reset mid-service
        pulse(4);
        pulse(4);
        check("pending_ovf", overflow, 31'h10);
        rst = 1'b1; tick(); rst = 1'b0;
        check("midrst_pending", pending, 31'h0);
        check("midrst_overflow", overflow, 31'h0);
        check("midrst_mode", mode_out, 31'h0);
        cfg_we = 1'b1; cfg_mode = 31'h1;
        tick();
        cfg_we = 1'b0;
        tick();
        check("postrst_not_yet", pending, 31'h0);
        tick();
        check("postrst_repend", pending, 31'h43);
        claim(5'd1);
        complete(5'd1);
        tick(); tick();
        check("postrst_single_edge", pending, 31'h42);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
